alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the ALU.
- Registers the decoded instruction and drives the ALU operands (inputA, inputB) and aluOP.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Stalls on load-use hazards.
- Uses a valid/ready handshake on both sides and supports a synchronous pipeline flush.

Parameters:
- XLEN, 32, datapath width of operands, pc and imm
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  core clock, rising edge
- nRst  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of the held instruction (branch/jump redirect)
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_alu_op  in  4  ALU opcode (aluop_t encoding)
- in_rs1, in_rs2  in  REG_ADDR_W  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm, in_pc  in  XLEN  immediate, instruction pc
- in_use_imm, in_use_pc  in  1  operand B = imm; operand A = pc
- in_rd  in  REG_ADDR_W  destination index
- in_reg_write  in  1  instruction writes rd
- out_valid  out  1  operands are valid for the ALU
- out_ready  in  1  execute stage consumes
- inputA, inputB  out  XLEN  ALU operands
- aluOP  out  4  ALU opcode
- out_rd  out  REG_ADDR_W  held rd
- out_reg_write  out  1  held reg_write
- out_pc  out  XLEN  held pc
- fwd_mem_valid  in  1  MEM stage writes fwd_mem_rd
- fwd_mem_rd  in  REG_ADDR_W  MEM stage destination
- fwd_mem_data  in  XLEN  MEM stage result
- fwd_mem_pending  in  1  MEM instruction is a load whose data is not yet available
- fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/REG_ADDR_W/XLEN  WB stage write port

Behaviour:
- Reset (nRst low, asynchronous): state=EMPTY; all held fields 0; out_valid=0; aluOP=0 (ALU_ADD); inputA=inputB=0; in_ready=1 once reset is released.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - HOLD: out_valid=1, in_ready=out_ready.
  - HAZARD: out_valid=0, in_ready=0.
- Capture occurs when in_valid && in_ready at a clock edge.
  - Each source is stored after forwarding: rs==0 gives 0; else a MEM match (fwd_mem_valid, rd equal, not pending) gives fwd_mem_data; else a WB match gives fwd_wb_data; else the in_*_data value.
- Load-use: a source that matches MEM with fwd_mem_pending=1 (rs!=0) sets the next state to HAZARD; otherwise the next state is HOLD.
- Refresh: every cycle in HOLD or HAZARD, each held source is overwritten by a forward hit using the same priority and x0 rule, with no new capture.
  - HAZARD goes to HOLD on the first edge where no held source matches a pending MEM entry.
- HOLD transitions:
  - out_ready && in_valid: capture the new instruction (back-to-back, 1 instruction/cycle).
  - out_ready && !in_valid: go to EMPTY.
  - !out_ready: remain in HOLD and keep all fields stable.
- Operand outputs: inputA = held use_pc ? held pc : held rs1 value; inputB = held use_imm ? held imm : held rs2 value.
  - Combinational from registers only; no input-to-output combinational path except in_ready from out_ready.
- Latency: an instruction accepted at edge N has out_valid high in cycle N+1 unless it enters HAZARD.
- flush has highest priority: the next state is EMPTY and reg_write is cleared; in_valid in a flush cycle is dropped (in_ready is still reported, no capture).
- The out_valid=1 to 0 transition is only allowed by consumption, flush or reset.
- Wrap-around: pc and imm are passed unchanged; no arithmetic is performed in this stage.

Optional Feature:
- Macro: ALU_FWD_BYPASS_EN.
- Defined: forwarding and refresh as above; HAZARD is reachable only via fwd_mem_pending.
- Undefined: no forwarding. Any source matching a valid MEM or WB destination (rs!=0) holds the stage in HAZARD until no match remains; operands are then re-read from in_*_data latched at capture. Software NOP insertion is not required.

Decomposition:
- Package alu_pkg holds aluop_t (ADD=0, SUB=1, OR=2, XOR=3, AND=4, SLL=5, SRA=6, SLTU=7, SLT=8, SRL=9) and opstage_state_t (EMPTY, HOLD, HAZARD); the ALU also imports aluop_t.
- One sub-module, alu_fwd_select: a combinational priority mux (rs, stored data, MEM port, WB port -> value, hit, pending_hit), instantiated twice.

Test Plan:
- Reset mid-HOLD (aluOP=SUB held), nRst low → out_valid=0, aluOP=0, inputA=0 immediately; first capture after release works.
- Accept add x3,x1,x2 (rs1_data=5, rs2_data=7) with out_ready=1 → next cycle out_valid=1, inputA=5, inputB=7; a second instruction the following cycle gives back-to-back output.
- MEM forward fwd_mem_rd=1 (data 0x10) and WB fwd_wb_rd=1 (data 0x20) both valid at capture → inputA=0x10; with rs1=0 and fwd rd=0 → inputA=0.
- Load-use: rs2=4, fwd_mem_rd=4, pending=1 → out_valid=0 for 2 cycles; pending drops with data 0xDEAD → inputB=0xDEAD and out_valid=1.
- out_ready=0 for 3 cycles while in_valid=1 → in_ready=0 and outputs stable; out_ready=1 → new instruction captured.
- flush in HOLD with in_valid=1 → EMPTY next cycle, out_valid=0, incoming instruction dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and operand-stage state type.
// The ALU imports aluop_t from this package as well.
package alu_pkg;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SRL  = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    HAZARD = 2'd2
  } opstage_state_t;
endpackage

// File: rtl/alu_operand_stage_if.sv
// Decoder-side, execute-side and forwarding-port signals of the ALU operand stage.
// master drives instructions and forwards, slave is the stage itself.
interface alu_operand_stage_if #(
    parameter int XLEN       = alu_pkg::XLEN_DEF,
    parameter int REG_ADDR_W = alu_pkg::REG_ADDR_W_DEF
);
    logic                  in_valid, in_ready;
    logic [3:0]            in_alu_op;
    logic [REG_ADDR_W-1:0] in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0]       in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic                  in_use_imm, in_use_pc, in_reg_write;

    logic                  out_valid, out_ready;
    logic [XLEN-1:0]       inputA, inputB, out_pc;
    logic [3:0]            aluOP;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_write;

    logic                  fwd_mem_valid, fwd_mem_pending, fwd_wb_valid;
    logic [REG_ADDR_W-1:0] fwd_mem_rd, fwd_wb_rd;
    logic [XLEN-1:0]       fwd_mem_data, fwd_wb_data;

    modport slave (
        input  in_valid, in_alu_op, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
               in_imm, in_pc, in_use_imm, in_use_pc, in_reg_write, out_ready,
               fwd_mem_valid, fwd_mem_pending, fwd_mem_rd, fwd_mem_data,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
        output in_ready, out_valid, inputA, inputB, out_pc, aluOP, out_rd, out_reg_write
    );

    modport master (
        output in_valid, in_alu_op, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
               in_imm, in_pc, in_use_imm, in_use_pc, in_reg_write, out_ready,
               fwd_mem_valid, fwd_mem_pending, fwd_mem_rd, fwd_mem_data,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
        input  in_ready, out_valid, inputA, inputB, out_pc, aluOP, out_rd, out_reg_write
    );
endinterface

// File: rtl/alu_fwd_select.sv
// Per-source forwarding priority mux: x0 -> 0, MEM (not pending) -> WB -> stored data.
// pending_hit flags a MEM match whose load data is not yet available.
module alu_fwd_select #(
    parameter int XLEN       = alu_pkg::XLEN_DEF,
    parameter int REG_ADDR_W = alu_pkg::REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [XLEN-1:0]       data_i,
    input  logic                  mem_valid_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]       mem_data_i,
    input  logic                  mem_pending_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic [XLEN-1:0]       value_o,
    output logic                  hit_o,
    output logic                  pending_hit_o
);
    logic mem_match, wb_match;

    always_comb begin
        mem_match     = mem_valid_i && (mem_rd_i == rs_i) && (rs_i != '0);
        wb_match      = wb_valid_i && (wb_rd_i == rs_i) && (rs_i != '0);
        pending_hit_o = mem_match && mem_pending_i;
        hit_o         = 1'b0;
        value_o       = data_i;
        if (rs_i == '0) begin
            value_o = '0;
        end else if (mem_match && !mem_pending_i) begin
            value_o = mem_data_i;
            hit_o   = 1'b1;
        end else if (wb_match) begin
            value_o = wb_data_i;
            hit_o   = 1'b1;
        end
    end
endmodule

// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand stage: holds one instruction, forwards from MEM/WB, stalls on hazards.
// Define ALU_FWD_BYPASS_EN to enable forwarding; otherwise any MEM/WB match stalls in HAZARD.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                flush,
    alu_operand_stage_if.slave  bus
);
    opstage_state_t        state_q;
    aluop_t                alu_op_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]       rs1_val_q, rs2_val_q, imm_q, pc_q;
    logic                  use_imm_q, use_pc_q, reg_write_q;

    logic                  in_ready, capture, hazard_d;
    logic [REG_ADDR_W-1:0] rs1_sel, rs2_sel;
    logic [XLEN-1:0]       rs1_data_sel, rs2_data_sel, rs1_val_d, rs2_val_d;
    logic [XLEN-1:0]       fwd1_value, fwd2_value;
    logic                  fwd1_hit, fwd2_hit, fwd1_pend, fwd2_pend;

    assign in_ready = (state_q == EMPTY) || (state_q == HOLD && bus.out_ready);
    assign capture  = bus.in_valid && in_ready && !flush;

    // One mux per source serves both capture (incoming data) and refresh (held data).
    assign rs1_sel      = capture ? bus.in_rs1      : rs1_q;
    assign rs2_sel      = capture ? bus.in_rs2      : rs2_q;
    assign rs1_data_sel = capture ? bus.in_rs1_data : rs1_val_q;
    assign rs2_data_sel = capture ? bus.in_rs2_data : rs2_val_q;

    alu_fwd_select #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_i(rs1_sel), .data_i(rs1_data_sel),
        .mem_valid_i(bus.fwd_mem_valid), .mem_rd_i(bus.fwd_mem_rd),
        .mem_data_i(bus.fwd_mem_data), .mem_pending_i(bus.fwd_mem_pending),
        .wb_valid_i(bus.fwd_wb_valid), .wb_rd_i(bus.fwd_wb_rd), .wb_data_i(bus.fwd_wb_data),
        .value_o(fwd1_value), .hit_o(fwd1_hit), .pending_hit_o(fwd1_pend)
    );

    alu_fwd_select #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_i(rs2_sel), .data_i(rs2_data_sel),
        .mem_valid_i(bus.fwd_mem_valid), .mem_rd_i(bus.fwd_mem_rd),
        .mem_data_i(bus.fwd_mem_data), .mem_pending_i(bus.fwd_mem_pending),
        .wb_valid_i(bus.fwd_wb_valid), .wb_rd_i(bus.fwd_wb_rd), .wb_data_i(bus.fwd_wb_data),
        .value_o(fwd2_value), .hit_o(fwd2_hit), .pending_hit_o(fwd2_pend)
    );

`ifdef ALU_FWD_BYPASS_EN
    assign rs1_val_d = fwd1_value;
    assign rs2_val_d = fwd2_value;
    assign hazard_d  = fwd1_pend || fwd2_pend;
`else
    // Without bypass a hit keeps the raw register-file value; the stall covers the hazard.
    assign rs1_val_d = fwd1_hit ? rs1_data_sel : fwd1_value;
    assign rs2_val_d = fwd2_hit ? rs2_data_sel : fwd2_value;
    assign hazard_d  = fwd1_hit || fwd1_pend || fwd2_hit || fwd2_pend;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= EMPTY;
            alu_op_q    <= ALU_ADD;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            use_imm_q   <= 1'b0;
            use_pc_q    <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            state_q     <= EMPTY;
            reg_write_q <= 1'b0;
        end else if (capture) begin
            state_q     <= hazard_d ? HAZARD : HOLD;
            alu_op_q    <= aluop_t'(bus.in_alu_op);
            rs1_q       <= bus.in_rs1;
            rs2_q       <= bus.in_rs2;
            rd_q        <= bus.in_rd;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= bus.in_imm;
            pc_q        <= bus.in_pc;
            use_imm_q   <= bus.in_use_imm;
            use_pc_q    <= bus.in_use_pc;
            reg_write_q <= bus.in_reg_write;
        end else begin
            case (state_q)
                HOLD: begin
                    rs1_val_q <= rs1_val_d;
                    rs2_val_q <= rs2_val_d;
                    if (bus.out_ready) state_q <= EMPTY;
                end
                HAZARD: begin
                    rs1_val_q <= rs1_val_d;
                    rs2_val_q <= rs2_val_d;
                    if (!hazard_d) state_q <= HOLD;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = (state_q == HOLD);
    assign bus.inputA        = use_pc_q  ? pc_q  : rs1_val_q;
    assign bus.inputB        = use_imm_q ? imm_q : rs2_val_q;
    assign bus.aluOP         = alu_op_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_reg_write = reg_write_q;
    assign bus.out_pc        = pc_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: vector table plus hazard/stall/flush/reset sequences.
// Expectations follow ALU_FWD_BYPASS_EN in the same way as the design build.
module tb_alu_operand_stage;
    logic clk = 1'b0, nRst = 1'b0, flush = 1'b0;
    int   pass_cnt = 0, total = 0;

    alu_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
    alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (.clk(clk), .nRst(nRst), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic        use_imm, use_pc, rw;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic use_imm, input logic use_pc, input logic rw);
        bus.in_alu_op = op;   bus.in_rs1 = rs1;  bus.in_rs2 = rs2;
        bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_rd = rd;
        bus.in_imm = imm;     bus.in_pc = pc;
        bus.in_use_imm = use_imm; bus.in_use_pc = use_pc; bus.in_reg_write = rw;
    endtask

    task automatic clr_fwd();
        bus.fwd_mem_valid = 0; bus.fwd_mem_pending = 0; bus.fwd_mem_rd = 0; bus.fwd_mem_data = 0;
        bus.fwd_wb_valid = 0;  bus.fwd_wb_rd = 0;       bus.fwd_wb_data = 0;
    endtask

    initial begin
        vecs[0] = '{op:4'd0, rs1:5'd1, rs2:5'd2, rd:5'd3, d1:32'd5, d2:32'd7, imm:32'd0, pc:32'h100,
                    use_imm:0, use_pc:0, rw:1, exp_a:32'd5, exp_b:32'd7};
        vecs[1] = '{op:4'd1, rs1:5'd1, rs2:5'd0, rd:5'd4, d1:32'd100, d2:32'd55, imm:32'd0, pc:32'h104,
                    use_imm:0, use_pc:0, rw:1, exp_a:32'd100, exp_b:32'd0};
        vecs[2] = '{op:4'd2, rs1:5'd5, rs2:5'd6, rd:5'd5, d1:32'd9, d2:32'd1, imm:32'hFFFF_FFFF, pc:32'h1000,
                    use_imm:1, use_pc:0, rw:0, exp_a:32'd9, exp_b:32'hFFFF_FFFF};
        vecs[3] = '{op:4'd0, rs1:5'd7, rs2:5'd8, rd:5'd1, d1:32'd3, d2:32'd3, imm:32'd4, pc:32'hFFFF_FFFC,
                    use_imm:1, use_pc:1, rw:1, exp_a:32'hFFFF_FFFC, exp_b:32'd4};
        vecs[4] = '{op:4'd3, rs1:5'd31, rs2:5'd30, rd:5'd29, d1:32'hA5A5_A5A5, d2:32'h5A5A_5A5A, imm:32'd0,
                    pc:32'h2000, use_imm:0, use_pc:0, rw:1, exp_a:32'hA5A5_A5A5, exp_b:32'h5A5A_5A5A};

        bus.in_valid = 0; bus.out_ready = 0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr_fwd();
        #3;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("rst_aluOP", {28'd0, bus.aluOP}, 0);
        chk("rst_inputA", bus.inputA, 0);
        chk("rst_inputB", bus.inputB, 0);
        @(negedge clk) nRst = 1;

        // back-to-back vectors, one per cycle
        for (int i = 0; i < 5; i++) begin
            drv(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2, vecs[i].rd,
                vecs[i].imm, vecs[i].pc, vecs[i].use_imm, vecs[i].use_pc, vecs[i].rw);
            bus.in_valid = 1; bus.out_ready = 1;
            step();
            chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, 1);
            chk($sformatf("v%0d_inputA", i), bus.inputA, vecs[i].exp_a);
            chk($sformatf("v%0d_inputB", i), bus.inputB, vecs[i].exp_b);
            chk($sformatf("v%0d_aluOP", i), {28'd0, bus.aluOP}, {28'd0, vecs[i].op});
            chk($sformatf("v%0d_out_pc", i), bus.out_pc, vecs[i].pc);
            chk($sformatf("v%0d_out_rd", i), {27'd0, bus.out_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_reg_write", i), {31'd0, bus.out_reg_write}, {31'd0, vecs[i].rw});
        end
        bus.in_valid = 0;
        step();
        chk("drain_out_valid", {31'd0, bus.out_valid}, 0);

        // asynchronous reset while holding a SUB
        drv(4'd1, 5'd1, 5'd2, 32'd9, 32'd1, 5'd3, 0, 32'h40, 0, 0, 1);
        bus.in_valid = 1; bus.out_ready = 0;
        step();
        chk("hold_sub_aluOP", {28'd0, bus.aluOP}, 1);
        bus.in_valid = 0;
        #2 nRst = 0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("midrst_aluOP", {28'd0, bus.aluOP}, 0);
        chk("midrst_inputA", bus.inputA, 0);
        #1 nRst = 1;
        drv(4'd0, 5'd2, 5'd0, 32'h77, 32'd0, 5'd3, 0, 32'h44, 0, 0, 1);
        bus.in_valid = 1; bus.out_ready = 1;
        step();
        chk("postrst_out_valid", {31'd0, bus.out_valid}, 1);
        chk("postrst_inputA", bus.inputA, 32'h77);
        bus.in_valid = 0;
        step();

        // MEM and WB both match rs1
        drv(4'd0, 5'd1, 5'd2, 32'hAA, 32'd3, 5'd3, 0, 32'h50, 0, 0, 1);
        bus.fwd_mem_valid = 1; bus.fwd_mem_rd = 1; bus.fwd_mem_data = 32'h10;
        bus.fwd_wb_valid = 1;  bus.fwd_wb_rd = 1;  bus.fwd_wb_data = 32'h20;
        bus.in_valid = 1;
        step();
        bus.in_valid = 0;
`ifdef ALU_FWD_BYPASS_EN
        chk("fwd_out_valid", {31'd0, bus.out_valid}, 1);
        chk("fwd_mem_prio_inputA", bus.inputA, 32'h10);
        clr_fwd();
        step();
`else
        chk("nofwd_hazard_out_valid", {31'd0, bus.out_valid}, 0);
        chk("nofwd_hazard_in_ready", {31'd0, bus.in_ready}, 0);
        clr_fwd();
        step();
        chk("nofwd_release_out_valid", {31'd0, bus.out_valid}, 1);
        chk("nofwd_latched_inputA", bus.inputA, 32'hAA);
        step();
`endif
        chk("fwd_drain_out_valid", {31'd0, bus.out_valid}, 0);

        // x0 never forwards
        drv(4'd0, 5'd0, 5'd2, 32'h55, 32'd3, 5'd3, 0, 32'h54, 0, 0, 1);
        bus.fwd_mem_valid = 1; bus.fwd_mem_rd = 0; bus.fwd_mem_data = 32'h10;
        bus.in_valid = 1;
        step();
        bus.in_valid = 0;
        chk("x0_out_valid", {31'd0, bus.out_valid}, 1);
        chk("x0_inputA", bus.inputA, 0);
        clr_fwd();
        step();

        // load-use on rs2
        drv(4'd0, 5'd0, 5'd4, 32'd0, 32'h11, 5'd3, 0, 32'h58, 0, 0, 1);
        bus.fwd_mem_valid = 1; bus.fwd_mem_rd = 4; bus.fwd_mem_pending = 1; bus.fwd_mem_data = 0;
        bus.in_valid = 1;
        step();
        bus.in_valid = 0;
        chk("lu_cyc1_out_valid", {31'd0, bus.out_valid}, 0);
        step();
        chk("lu_cyc2_out_valid", {31'd0, bus.out_valid}, 0);
        chk("lu_in_ready", {31'd0, bus.in_ready}, 0);
        bus.fwd_mem_pending = 0; bus.fwd_mem_data = 32'hDEAD;
        step();
`ifdef ALU_FWD_BYPASS_EN
        chk("lu_release_out_valid", {31'd0, bus.out_valid}, 1);
        chk("lu_inputB", bus.inputB, 32'hDEAD);
`else
        chk("lu_still_hazard", {31'd0, bus.out_valid}, 0);
        bus.fwd_mem_valid = 0;
        step();
        chk("lu_release_out_valid", {31'd0, bus.out_valid}, 1);
        chk("lu_inputB", bus.inputB, 32'h11);
`endif
        clr_fwd();
        step();

        // backpressure for 3 cycles
        drv(4'd0, 5'd6, 5'd0, 32'h66, 32'd0, 5'd3, 0, 32'h60, 0, 0, 1);
        bus.in_valid = 1; bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        drv(4'd3, 5'd7, 5'd0, 32'h77, 32'd0, 5'd8, 0, 32'h64, 0, 0, 1);
        #1;
        chk("stall_in_ready", {31'd0, bus.in_ready}, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d_out_valid", c), {31'd0, bus.out_valid}, 1);
            chk($sformatf("stall%0d_inputA", c), bus.inputA, 32'h66);
            chk($sformatf("stall%0d_in_ready", c), {31'd0, bus.in_ready}, 0);
        end
        bus.out_ready = 1;
        #1;
        chk("unstall_in_ready", {31'd0, bus.in_ready}, 1);
        step();
        chk("unstall_inputA", bus.inputA, 32'h77);
        chk("unstall_aluOP", {28'd0, bus.aluOP}, 3);
        chk("unstall_out_pc", bus.out_pc, 32'h64);

        // flush in HOLD drops the incoming instruction
        flush = 1;
        drv(4'd4, 5'd8, 5'd0, 32'h88, 32'd0, 5'd9, 0, 32'h68, 0, 0, 1);
        bus.in_valid = 1;
        step();
        chk("flush_out_valid", {31'd0, bus.out_valid}, 0);
        chk("flush_reg_write", {31'd0, bus.out_reg_write}, 0);
        flush = 0; bus.in_valid = 0;
        step();
        chk("flush_dropped_out_valid", {31'd0, bus.out_valid}, 0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
